// File: rtl/gcd_core.sv
// -----------------------------------------------------------------------------
// gcd_core
//   Iterative subtractive GCD engine. A start pulse in IDLE captures two
//   unsigned operands. The engine then takes one subtract step per clock until
//   one operand is zero or both are equal. It returns gcd(a_in, b_in) on
//   gcd_out and raises done for exactly one cycle.
//
//   Ports
//     clk      in   1      rising-edge clock
//     reset    in   1      asynchronous, active-low reset
//     start    in   1      request; only looked at in IDLE
//     a_in     in   WIDTH  operand A, captured on the start edge
//     b_in     in   WIDTH  operand B, captured on the start edge
//     busy     out  1      high while iterating (CALC)
//     done     out  1      one-cycle strobe (DONE)
//     gcd_out  out  WIDTH  last result; held until the next termination
// -----------------------------------------------------------------------------
module gcd_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] gcd_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_gcd;

   logic             w_a_en;
   logic             w_b_en;
   logic             w_gcd_en;
   logic [WIDTH-1:0] w_a_next;
   logic [WIDTH-1:0] w_b_next;
   logic [WIDTH-1:0] w_gcd_next;

   // Differences are only used when the minuend is strictly larger,
   // so neither wraps.
   logic [WIDTH-1:0] w_a_minus_b;
   logic [WIDTH-1:0] w_b_minus_a;

   assign w_a_minus_b = r_a - r_b;
   assign w_b_minus_a = r_b - r_a;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------ next state / datapath
   always_comb begin
      w_state_next = r_state;
      w_a_en       = 1'b0;
      w_b_en       = 1'b0;
      w_gcd_en     = 1'b0;
      w_a_next     = r_a;
      w_b_next     = r_b;
      w_gcd_next   = r_gcd;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_a_en       = 1'b1;
               w_b_en       = 1'b1;
               w_a_next     = a_in;
               w_b_next     = b_in;
               w_state_next = S_CALC;
            end
         end

         S_CALC: begin
            // Termination tests come before any subtraction, in this order.
            if (r_a == '0) begin
               w_gcd_en     = 1'b1;
               w_gcd_next   = r_b;
               w_state_next = S_DONE;
            end else if (r_b == '0) begin
               w_gcd_en     = 1'b1;
               w_gcd_next   = r_a;
               w_state_next = S_DONE;
            end else if (r_a == r_b) begin
               w_gcd_en     = 1'b1;
               w_gcd_next   = r_a;
               w_state_next = S_DONE;
            end else if (r_a > r_b) begin
               w_a_en   = 1'b1;
               w_a_next = w_a_minus_b;
            end else begin
               w_b_en   = 1'b1;
               w_b_next = w_b_minus_a;
            end
         end

         S_DONE: begin
            w_state_next = S_IDLE;
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------ enable-gated data registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a <= '0;
      end else if (w_a_en) begin
         r_a <= w_a_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_b <= '0;
      end else if (w_b_en) begin
         r_b <= w_b_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gcd <= '0;
      end else if (w_gcd_en) begin
         r_gcd <= w_gcd_next;
      end
   end

   // --------------------------------------------------- Moore outputs
   assign busy    = (r_state == S_CALC);
   assign done    = (r_state == S_DONE);
   assign gcd_out = r_gcd;

endmodule

// File: tb/tb_gcd_core.sv
module tb_gcd_core;

   localparam int WIDTH = 4;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] gcd_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [WIDTH-1:0] g;
      int               busy_cycles;
      int               a;
      int               b;
   } exp_t;

   exp_t sb_q[$];

   gcd_core #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .busy    (busy),
      .done    (done),
      .gcd_out (gcd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------ reference model
   // Euclid with modulo; gcd(0,x)=x, gcd(0,0)=0.
   function automatic int ref_gcd(input int a, input int b);
      int x = a;
      int y = b;
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Subtractions taken by the subtractive algorithm: the sum of the
   // Euclidean quotients, minus one (the last quotient ends on equality).
   function automatic int ref_steps(input int a, input int b);
      int hi;
      int lo;
      int r;
      int s = 0;
      if (a == 0 || b == 0) return 0;
      hi = (a > b) ? a : b;
      lo = (a > b) ? b : a;
      while (lo != 0) begin
         s  = s + hi / lo;
         r  = hi % lo;
         hi = lo;
         lo = r;
      end
      return s - 1;
   endfunction

   function automatic exp_t make_exp(input int a, input int b);
      exp_t e;
      e.g           = WIDTH'(ref_gcd(a, b));
      e.busy_cycles = ref_steps(a, b) + 1;
      e.a           = a;
      e.b           = b;
      return e;
   endfunction

   // ------------------------------------------------------------- monitor
   int  mon_busy_cnt = 0;
   logic mon_prev_done = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         mon_busy_cnt  = 0;
         mon_prev_done = 1'b0;
      end else begin
         if (busy) mon_busy_cnt++;
         if (done) begin
            checks++;
            if (mon_prev_done) begin
               errors++;
               $display("FAIL done_width: done high in consecutive cycles (actual 2+, required 1)");
            end
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: done with empty scoreboard, gcd_out=%0d", gcd_out);
            end else begin
               e = sb_q.pop_front();
               checks++;
               if (gcd_out !== e.g) begin
                  errors++;
                  $display("FAIL gcd(%0d,%0d): gcd_out=%0d required %0d", e.a, e.b, gcd_out, e.g);
               end
               if (mon_busy_cnt != e.busy_cycles) begin
                  errors++;
                  $display("FAIL latency(%0d,%0d): busy cycles=%0d required %0d",
                           e.a, e.b, mon_busy_cnt, e.busy_cycles);
               end
               $display("txn a=%0d b=%0d gcd_out=%0d exp=%0d busy_cycles=%0d exp=%0d",
                        e.a, e.b, gcd_out, e.g, mon_busy_cnt, e.busy_cycles);
            end
            mon_busy_cnt = 0;
         end
         mon_prev_done = done;
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic check_val(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   // Called #1 after a rising edge with the DUT in IDLE.
   task automatic issue(input int a, input int b);
      a_in  = WIDTH'(a);
      b_in  = WIDTH'(b);
      start = 1'b1;
      sb_q.push_back(make_exp(a, b));
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Waits for done, then checks the result is held in IDLE.
   task automatic wait_done(input int exp_g);
      int n = 0;
      bit seen = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         if (done) seen = 1;
         n++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout: no done within 40 cycles (required done)");
      end
      @(negedge clk);
      check_val("hold_gcd_out", int'(gcd_out), exp_g);
      check_val("idle_busy", int'(busy), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int a, input int b);
      issue(a, b);
      wait_done(ref_gcd(a, b));
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;

      // Reset state, no start
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_val("rst_busy", int'(busy), 0);
         check_val("rst_done", int'(done), 0);
         check_val("rst_gcd_out", int'(gcd_out), 0);
      end
      @(posedge clk);
      #1;

      // Directed cases
      run(8, 12);
      run(7, 7);
      run(0, 5);
      run(5, 0);
      run(0, 0);
      run(15, 1);
      run(1, 15);

      // Start pulse mid-CALC is ignored
      issue(9, 6);
      a_in  = 4'd4;
      b_in  = 4'd2;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      a_in = '0;
      b_in = '0;
      wait_done(3);
      run(4, 2);

      // Start held high through DONE is recaptured with fresh operands
      a_in  = 4'd6;
      b_in  = 4'd4;
      start = 1'b1;
      sb_q.push_back(make_exp(6, 4));
      begin
         int n = 0;
         bit seen = 0;
         while (!seen && n < 40) begin
            @(negedge clk);
            if (done) seen = 1;
            n++;
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL held_start_timeout: no done within 40 cycles");
         end
      end
      a_in = 4'd10;
      b_in = 4'd15;
      sb_q.push_back(make_exp(10, 15));
      @(posedge clk);      // DONE -> IDLE
      @(posedge clk);      // capture
      #1 start = 1'b0;
      a_in = '0;
      b_in = '0;
      wait_done(5);

      // Reset mid-CALC abandons the computation
      issue(15, 1);
      repeat (4) @(posedge clk);
      #2 reset = 1'b0;
      sb_q.delete();
      #1;
      check_val("midrst_busy", int'(busy), 0);
      check_val("midrst_done", int'(done), 0);
      check_val("midrst_gcd_out", int'(gcd_out), 0);
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_val("post_rst_done", int'(done), 0);
      end
      @(posedge clk);
      #1;
      run(12, 8);

      // Randomized back-to-back transactions
      for (int i = 0; i < 40; i++) begin
         run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end

      repeat (3) @(posedge clk);
      check_val("scoreboard_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
